bus_rr_sched: RTL
=================

// Module: bus_rr_sched
// PURPOSE
//  Round-robin scheduler sequencing packet transfers on the shared broadcast bus between DRIVERS agents.
//  Samples each driver FIFO's pending flag and head packet, grants one driver, drives the packet onto the bus,
//  decodes its destination ID (unicast/broadcast/invalid), strobes receiver push lines, then pops the source FIFO.
//  Sits between the per-driver FIFOs and the bus receivers; replaces ad-hoc bus sequencing in the bus generator.
// PARAMETERS
//  PCKG     16     packet width in bits; destination ID = d_in[PCKG-1 -: ID_W]
//  DRIVERS  4      number of driver/receiver agents (2..16)
//  ID_W     8      destination ID field width
//  BROD     8'hFF  broadcast destination ID
// PORTS
//  clk     in   1              system clock, all logic on rising edge
//  reset   in   1              synchronous, active-high reset
//  pndng   in   DRIVERS        bit i: driver i FIFO non-empty
//  d_in    in   DRIVERS*PCKG   head packet of driver i at [i*PCKG +: PCKG]
//  pop     out  DRIVERS        one-hot, 1-cycle pulse: pop head of granted FIFO
//  push    out  DRIVERS        receiver write strobes, 1-cycle pulse
//  d_out   out  PCKG           bus data, valid while push != 0
//  busy    out  1              high in any state except IDLE
//  bcast   out  1              1-cycle pulse with a broadcast push
//  drop    out  1              1-cycle pulse: packet discarded (invalid or self destination)
// BEHAVIOUR
//  Reset: state=IDLE, ptr=DRIVERS-1 (driver 0 wins first), pop=0, push=0, d_out=0, busy=0, bcast=0, drop=0.
//  FSM, all outputs registered:
//   IDLE: if |pndng -> ARB, else stay.
//   ARB: winner = first i with pndng[i], searched ptr+1, ptr+2, ... wrapping mod DRIVERS; latch src=winner,
//        pkt=d_in[winner] -> XFER. If pndng==0 in this cycle -> IDLE, ptr unchanged.
//   XFER: d_out<=pkt; dst=pkt[PCKG-1 -: ID_W];
//        dst==BROD -> push=all ones except bit src, bcast=1;
//        dst<DRIVERS && dst!=src -> push=onehot(dst);
//        else -> push=0, drop=1. -> POP.
//   POP: pop=onehot(src); ptr<=src; push/bcast/drop return to 0 -> IDLE.
//  Latency: pndng rise in IDLE -> push 3 cycles later, pop 4 cycles later; min 4 cycles per packet.
//  IDLE after POP is mandatory: lets registered FIFO pndng/d_in update before next arbitration.
//  d_out holds last transferred packet until next XFER; never 0-cleared except by reset.
//  pkt/src frozen from ARB; d_in/pndng changes after ARB are ignored for the current transfer.
//  Exactly one pop per granted packet, including dropped packets; never pop without a grant.
//  ptr wraps DRIVERS-1 -> 0; pointer arithmetic uses $clog2(DRIVERS) bits with explicit wrap (non-power-of-2 DRIVERS legal).
//  BROD takes precedence over range check; BROD >= DRIVERS required (elaboration assertion).
//  Reset in any state: next edge yields reset values; in-flight transfer abandoned, no pop issued.
// STRUCTURE
//  Package bus_pkg: typedef enum logic [1:0] {IDLE, ARB, XFER, POP} sched_state_t; function onehot(idx, n).
//  Sub-module rr_pick #(N): combinational; inputs req[N], ptr -> gnt_idx, gnt_vld. Rest inline in bus_rr_sched.
// TESTING (DRIVERS=4, PCKG=16, ID_W=8, BROD=8'hFF)
//  1 Reset held 2 cycles with pndng=4'hF -> all outputs 0, busy=0; first grant after release goes to driver 0.
//  2 pndng=0001, d_in[0]=16'h0255 -> cycle 3: push=0100, d_out=16'h0255; cycle 4: pop=0001; then busy=0.
//  3 pndng=1111 held, all unicast valid -> grant order 0,1,2,3,0, one pop every 4 cycles.
//  4 Driver 2 sends 16'hFFAA -> push=1011, bcast=1 for 1 cycle, then pop=0100.
//  5 Driver 1 sends 16'h0433 (dest 4), then 16'h0133 (self) -> drop=1, push=0, pop=0010 both times.
//  6 Reset asserted in XFER cycle -> push=0 next edge, no pop, ptr=3, next grant to driver 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and helpers for the broadcast-bus round-robin scheduler.
package bus_pkg;

  typedef enum logic [1:0] {IDLE, ARB, XFER, POP} sched_state_t;

  localparam int MAX_DRIVERS = 16;

  // Bit idx set, or all zeros when idx falls outside the first n agents.
  function automatic logic [MAX_DRIVERS-1:0] onehot(input int idx, input int n);
    logic [MAX_DRIVERS-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DRIVERS; i++) begin
      if (i == idx && i < n) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/bus_rr_sched_if.sv
// Scheduler-side bundle: driver FIFO status/heads in, pops, receiver strobes and bus data out.
interface bus_rr_sched_if #(
  parameter int DRIVERS = 4,
  parameter int PCKG    = 16
);

  logic [DRIVERS-1:0]      pndng;
  logic [DRIVERS*PCKG-1:0] d_in;
  logic [DRIVERS-1:0]      pop;
  logic [DRIVERS-1:0]      push;
  logic [PCKG-1:0]         d_out;
  logic                    busy;
  logic                    bcast;
  logic                    drop;

  modport master (
    input  pndng, d_in,
    output pop, push, d_out, busy, bcast, drop
  );

  modport slave (
    output pndng, d_in,
    input  pop, push, d_out, busy, bcast, drop
  );

endinterface

// File: rtl/bus_rr_sched_rr_pick.sv
// Combinational round-robin picker: first requester after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  function automatic int wrap_add(input int p, input int k);
    int s;
    s = p + k;
    return (s >= N) ? s - N : s;
  endfunction

  logic [W-1:0] cand;

  // Walk from the farthest candidate back to ptr+1 so the nearest requester wins last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = N; k >= 1; k--) begin
      cand = W'(wrap_add(int'(ptr), k));
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_sched.sv
// Round-robin bus scheduler: IDLE->ARB->XFER->POP, push 3 cycles and pop 4 cycles after pndng in IDLE.
// No backpressure from receivers; drivers are throttled only by the one-packet-per-4-cycles sequence.
module bus_rr_sched
  import bus_pkg::*;
#(
  parameter int              PCKG    = 16,
  parameter int              DRIVERS = 4,
  parameter int              ID_W    = 8,
  parameter logic [ID_W-1:0] BROD    = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  bus_rr_sched_if.master bus
);

  localparam int PW = $clog2(DRIVERS);

  if (int'(BROD) < DRIVERS) begin : g_brod_check
    $error("BROD collides with a receiver ID");
  end

  sched_state_t       state, state_nxt;
  logic [PW-1:0]      ptr, src, gnt_idx;
  logic               gnt_vld;
  logic [PCKG-1:0]    pkt;
  logic [ID_W-1:0]    dst;
  logic [DRIVERS-1:0] src_oh, dst_oh;
  logic [PCKG-1:0]    heads [DRIVERS];

  logic [DRIVERS-1:0] pop_q, pop_nxt, push_q, push_nxt;
  logic [PCKG-1:0]    dout_q, dout_nxt;
  logic               busy_q, busy_nxt, bcast_q, bcast_nxt, drop_q, drop_nxt;

  for (genvar i = 0; i < DRIVERS; i++) begin : g_heads
    assign heads[i] = bus.d_in[i*PCKG +: PCKG];
  end

  rr_pick #(.N(DRIVERS), .W(PW)) u_pick (
    .req     (bus.pndng),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  assign dst    = pkt[PCKG-1 -: ID_W];
  assign src_oh = DRIVERS'(onehot(int'(src), DRIVERS));
  assign dst_oh = DRIVERS'(onehot(int'(dst), DRIVERS));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (|bus.pndng) state_nxt = ARB;
      ARB:     state_nxt = gnt_vld ? XFER : IDLE;
      XFER:    state_nxt = POP;
      POP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop_nxt   = '0;
    push_nxt  = '0;
    bcast_nxt = 1'b0;
    drop_nxt  = 1'b0;
    dout_nxt  = dout_q;
    busy_nxt  = (state_nxt != IDLE);
    unique case (state)
      XFER: begin
        dout_nxt = pkt;
        // Broadcast is checked first: BROD lies outside the receiver ID range.
        if (dst == BROD) begin
          push_nxt  = ~src_oh;
          bcast_nxt = 1'b1;
        end else if (int'(dst) < DRIVERS && int'(dst) != int'(src)) begin
          push_nxt = dst_oh;
        end else begin
          drop_nxt = 1'b1;
        end
      end
      POP:     pop_nxt = src_oh;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_q   <= '0;
      push_q  <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      bcast_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      pop_q   <= pop_nxt;
      push_q  <= push_nxt;
      dout_q  <= dout_nxt;
      busy_q  <= busy_nxt;
      bcast_q <= bcast_nxt;
      drop_q  <= drop_nxt;
    end
  end

  // Grant and packet freeze in ARB; ptr only advances once the pop has gone out.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PW'(DRIVERS - 1);
      src <= '0;
      pkt <= '0;
    end else begin
      if (state == ARB && gnt_vld) begin
        src <= gnt_idx;
        pkt <= heads[gnt_idx];
      end
      if (state == POP) ptr <= src;
    end
  end

  assign bus.pop   = pop_q;
  assign bus.push  = push_q;
  assign bus.d_out = dout_q;
  assign bus.busy  = busy_q;
  assign bus.bcast = bcast_q;
  assign bus.drop  = drop_q;

endmodule
